// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle between requesters and rr_req_arbiter.
//   req       : per-requester level request (bit i = requester i)
//   done      : completion pulse for the currently held grant
//   gnt       : registered one-hot grant, zero when idle
//   gnt_idx   : binary index of the granted requester, zero when idle
//   gnt_valid : high while a grant is held
//   timeout   : one-cycle pulse when a grant is force-released
// master = requester/resource side, slave = arbiter side.
interface rr_req_arbiter_if #(
  parameter int N     = 16,
  parameter int IDX_W = 4
);
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (output req, output done,
                  input gnt, input gnt_idx, input gnt_valid, input timeout);
  modport slave  (input req, input done,
                  output gnt, output gnt_idx, output gnt_valid, output timeout);
endinterface

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter for one single-ported resource shared by up to 16
// requesters. The grant is registered and held until done; priority then
// rotates to the requester after the one just served. A pending request at
// the done edge is granted immediately (no idle bubble).
//
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : rr_req_arbiter_if.slave (req, done in; gnt, gnt_idx, gnt_valid,
//          timeout out)
//
// Optional feature: define RR_ARB_TIMEOUT_EN to build an 8-bit busy counter
// that force-releases a grant after TIMEOUT busy cycles without done.
// Without it, timeout is tied low and a grant is held until done.
module rr_req_arbiter #(
  parameter int N       = 16,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  rr_req_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] nxt_ptr, scan_ptr, win_idx;
  logic [IDX_W:0]   pos;
  logic             any_req, release_g, tmo_hit, load;

  assign any_req = |bus.req;

  // Requester after the one being served; used both as the new ptr and as
  // the scan origin for a back-to-back re-grant on the release edge.
  assign nxt_ptr  = (idx_q == IDX_W'(N-1)) ? '0 : idx_q + 1'b1;
  assign scan_ptr = (state_q == BUSY) ? nxt_ptr : ptr_q;

  // Circular first-set scan from scan_ptr. Walking offsets from the far end
  // back toward zero lets the closest set bit win the last assignment.
  always_comb begin
    win_idx = '0;
    pos     = '0;
    for (int k = N-1; k >= 0; k--) begin
      pos = {1'b0, scan_ptr} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
      if (bus.req[pos[IDX_W-1:0]]) win_idx = pos[IDX_W-1:0];
    end
  end

  assign release_g = bus.done | tmo_hit;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (release_g) begin
          ptr_d = nxt_ptr;
          if (any_req) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      gnt_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
      idx_d = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       tmo_q;

  // done wins over a coincident timeout, so the pulse only fires when the
  // counter alone causes the release.
  assign tmo_hit = (state_q == BUSY) && !bus.done && (cnt_q == 8'(TIMEOUT));

  // Counts BUSY cycles of the current grant; any release (and any new grant)
  // restarts it from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_hit;
      if (state_q == BUSY && !release_g) cnt_q <= cnt_q + 8'd1;
      else                               cnt_q <= '0;
    end
  end

  assign bus.timeout = tmo_q;
`else
  assign tmo_hit     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
module tb_rr_req_arbiter;
  localparam int N     = 16;
  localparam int IDX_W = 4;
  localparam int TMO   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_req_arbiter_if #(.N(N), .IDX_W(IDX_W)) ifc ();

  rr_req_arbiter #(.N(N), .IDX_W(IDX_W), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference state: is a grant held, whom, where priority starts
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_busy;  // busy cycles of current grant without done
  bit m_tmo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // first requester with req set, visiting ptr, ptr+1, ... circularly
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic model(input logic [N-1:0] r, input bit d, input bit rs);
    bit rel, tmo;
    tmo = 1'b0;
    if (rs) begin
      m_valid = 0; m_idx = 0; m_ptr = 0; m_busy = 0; m_tmo = 0;
      return;
    end
    if (!m_valid) begin
      if (r != 0) begin m_valid = 1; m_idx = pick(r, m_ptr); m_busy = 0; end
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      tmo = !d && (m_busy == TMO);
`endif
      rel = d || tmo;
      if (rel) begin
        m_ptr = (m_idx + 1) % N;
        m_busy = 0;
        if (r != 0) m_idx = pick(r, m_ptr);
        else begin m_valid = 0; m_idx = 0; end
      end else m_busy++;
    end
    m_tmo = tmo;
  endtask

  // apply inputs for one cycle, advance the model on the edge, check after it
  task automatic step(input logic [N-1:0] r, input bit d, input bit rs);
    logic [N-1:0] eg;
    ifc.req = r; ifc.done = d; rst = rs;
    @(posedge clk);
    model(r, d, rs);
    #1;
    eg = m_valid ? (N'(1) << m_idx) : '0;
    chk("gnt",       32'(ifc.gnt),       32'(eg));
    chk("gnt_idx",   32'(ifc.gnt_idx),   32'(m_idx));
    chk("gnt_valid", 32'(ifc.gnt_valid), 32'(m_valid));
    chk("timeout",   32'(ifc.timeout),   32'(m_tmo));
  endtask

  initial begin
    int ord[6];
    ord = '{0, 1, 15, 0, 1, 15};
    ifc.req = '0; ifc.done = 1'b0;

    // reset dominates full request vector
    step(16'hFFFF, 0, 1);
    step(16'hFFFF, 0, 1);
    chk("rst_gnt", 32'(ifc.gnt), 0);
    step(16'hFFFF, 0, 0);
    chk("rst_first_idx", 32'(ifc.gnt_idx), 0);

    // single requester, held after req drop, released on done
    step(16'h0000, 0, 1);
    step(16'h0020, 0, 0);
    chk("single_idx", 32'(ifc.gnt_idx), 5);
    step(16'h0000, 0, 0);
    step(16'h0000, 0, 0);
    chk("single_hold", 32'(ifc.gnt), 32'h0020);
    step(16'h0000, 1, 0);
    chk("single_rel", 32'(ifc.gnt_valid), 0);
    step(16'h0041, 0, 0);
    chk("single_ptr6", 32'(ifc.gnt_idx), 6);

    // rotation with back-to-back re-grants
    step(16'h0000, 0, 1);
    step(16'h8003, 0, 0);
    for (int i = 0; i < 6; i++) begin
      chk("rot_idx", 32'(ifc.gnt_idx), 32'(ord[i]));
      step(16'h8003, 1, 0);
      chk("rot_nobubble", 32'(ifc.gnt_valid), 1);
    end

    // wrap: serving 14 moves ptr to 15, so 0 beats 14
    step(16'h0000, 0, 1);
    step(16'h4000, 0, 0);
    step(16'h4001, 1, 0);
    chk("wrap_idx", 32'(ifc.gnt_idx), 0);

    // mid-grant reset
    step(16'h0000, 0, 1);
    step(16'h0008, 0, 0);
    step(16'h0008, 0, 0);
    step(16'h0008, 0, 1);
    chk("midrst_gnt", 32'(ifc.gnt), 0);
    step(16'h0008, 0, 0);
    chk("midrst_idx", 32'(ifc.gnt_idx), 3);

    // long hold without done
    step(16'h0000, 0, 1);
    step(16'h0004, 0, 0);
    for (int i = 0; i < 100; i++) step(16'h0010, 0, 0);
`ifndef RR_ARB_TIMEOUT_EN
    chk("hold100_idx", 32'(ifc.gnt_idx), 2);
`endif

    // randomized traffic against the model
    step(16'h0000, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] r;
      r = N'($urandom) & N'($urandom) & N'($urandom);
      if ($urandom_range(0, 9) == 0) r = '0;
      step(r, $urandom_range(0, 9) < 3, $urandom_range(0, 99) == 0);
      chk("onehot", 32'($onehot0(ifc.gnt)), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rr_req_arbiter.md
Name: rr_req_arbiter

Overview:
- Round-robin arbiter that shares one single-ported resource between up to 16 requesters, e.g. one memory/bus port used by IFU, LSU and DMA-style masters.
- Registers the grant and holds it until the resource signals completion.
- Emits the grant as one-hot plus binary index (bit i maps to index i) for the datapath mux select.
- Priority rotates to the requester after the last one served.

Parameters:
- N, 16, number of requesters (2..16); req/gnt width.
- IDX_W, 4, width of gnt_idx; must satisfy 2^IDX_W >= N.
- TIMEOUT, 255, max busy cycles before forced release (used only with the optional feature); 8-bit counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req  in  N  request vector, level-sensitive; bit i = requester i.
- done  in  1  resource completion pulse for the current grant.
- gnt  out  N  registered one-hot grant; all-zero when idle.
- gnt_idx  out  IDX_W  binary index of the set bit of gnt; 0 when idle.
- gnt_valid  out  1  high while a grant is held (equals |gnt).
- timeout  out  1  one-cycle pulse on forced release; constant 0 when the feature is compiled out.

Behaviour:
- Reset (rst=1 at posedge): state IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, busy counter=0. rst overrides all other inputs, including mid-grant: the grant drops at that edge.
- States: IDLE, BUSY.
- Grant selection:
  - Winner is the first set req bit, scanning circularly from ptr upward: ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Pure function of the req and ptr values sampled at the edge.
- IDLE:
  - req==0: stay IDLE.
  - Any req bit set: at the next edge gnt/gnt_idx/gnt_valid are loaded with the winner and state becomes BUSY. Latency from req rising to gnt_valid is 1 cycle.
  - done is ignored in IDLE.
- BUSY:
  - gnt and gnt_idx stay frozen regardless of req changes, including when the granted requester drops its req.
  - On done=1:
    - ptr <= (gnt_idx+1) mod N.
    - If any req bit is set at that same edge, the new winner is computed with the updated ptr and loaded directly, with no idle bubble, and state stays BUSY.
    - The just-served requester still competes, but at lowest priority.
    - Otherwise gnt<=0 and state goes to IDLE.
- Wrap-around: gnt_idx=N-1 with done gives ptr=0.
- Starvation bound: a continuously asserted request is granted within N-1 grant completions.
- gnt_idx is always the binary encoding of gnt. gnt always has zero or exactly one bit set.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit busy counter clears on every new grant and increments each BUSY cycle without done.
  - When the counter equals TIMEOUT and done is 0, the arbiter releases exactly as if done were 1 (ptr advance and back-to-back re-grant rules apply).
  - timeout=1 for that one cycle, on the edge where the release takes effect.
  - done and timeout in the same cycle count as done, with timeout=0.
- Not defined: no counter is built. timeout is tied to 0. A grant is held until done, indefinitely.

Test Plan:
- Reset: assert rst 2 cycles with req=16'hFFFF -> gnt=0, gnt_idx=0, gnt_valid=0 during and 1 cycle after. First grant after release of rst is index 0.
- Single requester: req=16'h0020 at cycle 0 -> cycle 1 gnt=16'h0020, gnt_idx=5. Drop req at cycle 2 -> grant held. done at cycle 4 -> cycle 5 gnt=0, IDLE, ptr=6.
- Rotation: req=16'h8003 held, done pulsed 1 cycle after each grant -> grant order idx 0,1,15,0,1,15 with no idle cycles between grants.
- Wrap: ptr=15 via a served grant on idx 14, req=16'h4001 -> next winner idx 0, not 14.
- Mid-grant reset: grant on idx 3, rst at cycle 3 -> cycle 4 gnt=0. After rst release, req=16'h0008 -> idx 3 granted with ptr=0.
- Timeout (RR_ARB_TIMEOUT_EN, TIMEOUT=4): grant idx 2, no done -> released after 4 busy cycles with timeout=1 for 1 cycle. Pending req=16'h0010 -> idx 4 granted the same edge. Without the macro the grant persists for 100 cycles and timeout stays 0.
